gb_lcd_capture: RTL and testbench

//  Captures the Game Boy LCD bus (pixel clock, hsync, vsync, 2-bit data) into the pllclk domain.

---
 rtl/gb_lcd_capture.sv | 156 +++++++++++++++
 tb/tb_gb_lcd_capture.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gb_lcd_capture.sv
// Game Boy LCD bus capture into the pllclk domain, emitting a linear frame-buffer write stream.
// Define GB_CAPTURE_DOUBLE_BUFFER_EN to add a bank bit on wr_addr and an rd_bank output.
module gb_lcd_capture #(
  parameter int H_PIXELS    = 160,
  parameter int V_LINES     = 144,
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gb_clk,
  input  logic              gb_hsync,
  input  logic              gb_vsync,
  input  logic [1:0]        gb_data,
  output logic              wr_en,
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  output logic [ADDR_W:0]   wr_addr,
`else
  output logic [ADDR_W-1:0] wr_addr,
`endif
  output logic [1:0]        wr_data,
  output logic              frame_done,
  output logic              overrun
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  , output logic            rd_bank
`endif
);

  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES);

  typedef enum logic [1:0] {IDLE, LINE, DRAIN} state_t;

  // bit 0 clk, bit 1 hsync, bit 2 vsync, bits 4:3 data; all share one chain so they stay aligned
  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [4:0]                  s_last;
  logic                        clk_d, hs_d;
  logic                        pix_ev, line_ev, frame_ev;
  logic [1:0]                  pix_data;

  state_t             state, state_n;
  logic [XW-1:0]      x, x_n;
  logic [YW-1:0]      y, y_n;
  logic [ADDR_W-1:0]  base, base_n, addr_n;
  logic               we_n, done_n, ovr_n, done_pend;
  logic [1:0]         data_n;
  logic               bank;

  assign s_last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      clk_d    <= 1'b0;
      hs_d     <= 1'b0;
      pix_ev   <= 1'b0;
      line_ev  <= 1'b0;
      frame_ev <= 1'b0;
      pix_data <= 2'b00;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], {gb_data, gb_vsync, gb_hsync, gb_clk}};
      clk_d    <= s_last[0];
      hs_d     <= s_last[1];
      pix_ev   <= clk_d & ~s_last[0];
      line_ev  <= ~hs_d & s_last[1];
      frame_ev <= s_last[2];
      pix_data <= s_last[4:3];
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    base_n  = base;
    we_n    = 1'b0;
    addr_n  = wr_addr[ADDR_W-1:0];
    data_n  = wr_data;
    done_n  = 1'b0;
    ovr_n   = overrun;
    // Line/frame events are resolved first so a coincident pixel lands on the new line.
    if (line_ev) begin
      if (frame_ev) begin
        state_n = LINE;
        x_n     = '0;
        y_n     = '0;
        base_n  = '0;
      end else if (state == LINE) begin
        if (y == YW'(V_LINES - 1)) begin
          ovr_n   = 1'b1;
          state_n = DRAIN;
        end else begin
          y_n    = y + YW'(1);
          base_n = base + ADDR_W'(H_PIXELS);
          x_n    = '0;
        end
      end
    end
    if (pix_ev && state_n == LINE) begin
      if (x_n < XW'(H_PIXELS)) begin
        we_n   = 1'b1;
        addr_n = base_n + ADDR_W'(x_n);
        data_n = pix_data;
        x_n    = x_n + XW'(1);
        if (x_n == XW'(H_PIXELS) && y_n == YW'(V_LINES - 1)) begin
          done_n  = 1'b1;
          state_n = DRAIN;
        end
      end else begin
        ovr_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      base       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 2'b00;
      done_pend  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      base       <= base_n;
      wr_en      <= we_n;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
      wr_addr    <= {bank, addr_n};
`else
      wr_addr    <= addr_n;
`endif
      wr_data    <= data_n;
      done_pend  <= done_n;
      frame_done <= done_pend;
      overrun    <= ovr_n;
    end
  end

`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  // Bank flips together with frame_done, so only completed frames swap buffers.
  always_ff @(posedge clk) begin
    if (reset) bank <= 1'b0;
    else       bank <= bank ^ done_pend;
  end
  assign rd_bank = ~bank;
`else
  assign bank = 1'b0;
`endif

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Scoreboard bench for gb_lcd_capture on a reduced 16x8 geometry; directed GB bus vectors.
module tb_gb_lcd_capture;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AW = 7;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  localparam int WA = AW + 1;
`else
  localparam int WA = AW;
`endif
  localparam logic [AW-1:0] LAST = AW'(H * V - 1);

  logic clk = 1'b0;
  logic reset, gb_clk, gb_hsync, gb_vsync;
  logic [1:0] gb_data;
  logic wr_en, frame_done, overrun;
  logic [WA-1:0] wr_addr;
  logic [1:0] wr_data;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  logic rd_bank;
`endif

  gb_lcd_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .gb_clk(gb_clk), .gb_hsync(gb_hsync), .gb_vsync(gb_vsync),
    .gb_data(gb_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .overrun(overrun)
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
    , .rd_bank(rd_bank)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WA-1:0] a;
    logic [1:0]    d;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   checks = 0;
  int   fails = 0;
  int   done_cnt = 0;
  logic exp_bank = 1'b0;
  logic prev_we = 1'b0;
  logic [WA-1:0] prev_addr = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input int a, input logic [1:0] d);
    wr_t r;
    logic [AW-1:0] t;
    t = a[AW-1:0];
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
    r.a = {exp_bank, t};
`else
    r.a = t;
`endif
    r.d = d;
    return r;
  endfunction

  // Monitor: every write must match the head of the queue; frame_done must follow the last pixel.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", wr_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", int'(wr_addr), int'(mon_e.a));
          check("wr_data", int'(wr_data), int'(mon_e.d));
        end
      end
      if (frame_done) begin
        done_cnt++;
        check("frame_done_prev_we", int'(prev_we), 1);
        check("frame_done_prev_addr", int'(prev_addr[AW-1:0]), int'(LAST));
      end
    end
    prev_we   = wr_en;
    prev_addr = wr_addr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [1:0] d, input int addr, input bit expect_wr);
    if (expect_wr) exp_q.push_back(mk(addr, d));
    gb_data = d;
    gb_clk  = 1'b1;
    tick(2);
    gb_clk  = 1'b0;
    tick(2);
  endtask

  task automatic line_start(input logic vs);
    gb_vsync = vs;
    gb_hsync = 1'b1;
    tick(2);
    gb_hsync = 1'b0;
    gb_vsync = 1'b0;
    tick(2);
  endtask

  task automatic full_frame(input int seed);
    line_start(1'b1);
    for (int y = 0; y < V; y++) begin
      if (y > 0) line_start(1'b0);
      for (int i = 0; i < H; i++) pixel(2'(y + i + seed), y * H + i, 1'b1);
    end
    tick(8);
  endtask

  initial begin
    reset = 1'b1; gb_clk = 1'b0; gb_hsync = 1'b0; gb_vsync = 1'b0; gb_data = 2'b00;
    // 1: reset held with toggling bus
    for (int i = 0; i < 4; i++) begin
      gb_clk = i[0]; gb_hsync = ~i[0]; gb_vsync = i[1]; gb_data = 2'(i);
      @(negedge clk);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
    end
    gb_clk = 1'b0; gb_hsync = 1'b0; gb_vsync = 1'b0; gb_data = 2'b00;
    tick(2);
    reset = 1'b0;
    tick(2);
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
    check("rd_bank_reset", int'(rd_bank), 1);
`endif

    // 2: full frame, addresses 0..H*V-1, single frame_done
    full_frame(0);
    check("frame1_done_cnt", done_cnt, 1);
    check("frame1_overrun", int'(overrun), 0);
    check("frame1_queue", exp_q.size(), 0);
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
    check("rd_bank_frame1", int'(rd_bank), 0);
`endif
    exp_bank = ~exp_bank;

    // 3: line 5 with H+1 pixel clocks -> overrun, line 6 starts at 6*H
    line_start(1'b1);
    for (int y = 0; y <= 5; y++) begin
      if (y > 0) line_start(1'b0);
      for (int i = 0; i < H; i++) pixel(2'(3 - i), y * H + i, 1'b1);
    end
    pixel(2'b11, 0, 1'b0);
    tick(6);
    check("line_overrun", int'(overrun), 1);
    line_start(1'b0);
    pixel(2'b01, 6 * H, 1'b1);
    tick(6);
    check("line6_queue", exp_q.size(), 0);

    // 4: frame restart mid-frame (y=6) -> address 0, no frame_done
    line_start(1'b1);
    for (int i = 0; i < H; i++) pixel(2'(i), i, 1'b1);
    tick(6);
    check("restart_no_done", done_cnt, 1);

    // 5: hsync rise and gb_clk fall together after a full line 0 -> written at H
    exp_q.push_back(mk(H, 2'b10));
    gb_data = 2'b10; gb_clk = 1'b1;
    tick(2);
    gb_hsync = 1'b1; gb_clk = 1'b0;
    tick(2);
    gb_hsync = 1'b0;
    tick(6);
    check("coincident_queue", exp_q.size(), 0);

    // 7: reset mid-frame clears overrun; hsync past the last line -> overrun and drain
    reset = 1'b1;
    tick(2);
    check("rst2_wr_en", int'(wr_en), 0);
    check("rst2_overrun", int'(overrun), 0);
    reset = 1'b0;
    exp_bank = 1'b0;
    tick(2);
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
    check("rd_bank_reset2", int'(rd_bank), 1);
`endif
    line_start(1'b1);
    repeat (V - 1) line_start(1'b0);
    tick(4);
    check("last_line_no_overrun", int'(overrun), 0);
    line_start(1'b0);
    tick(4);
    check("extra_line_overrun", int'(overrun), 1);
    pixel(2'b01, 0, 1'b0);
    line_start(1'b0);
    pixel(2'b10, 0, 1'b0);
    tick(6);
    check("drain_queue", exp_q.size(), 0);
    check("drain_no_done", done_cnt, 1);

    // 6: two complete frames, bank alternates
    full_frame(1);
    check("frameA_done_cnt", done_cnt, 2);
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
    check("rd_bank_frameA", int'(rd_bank), 0);
`endif
    exp_bank = ~exp_bank;
    full_frame(2);
    check("frameB_done_cnt", done_cnt, 3);
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
    check("rd_bank_frameB", int'(rd_bank), 1);
`endif
    exp_bank = ~exp_bank;

    check("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
